axi_llc_tag_sram_ctrl: RTL and testbench
========================================

AXI_LLC_TAG_SRAM_CTRL -- requirements
Module: axi_llc_tag_sram_ctrl

Interface
REQ-001 The block SHALL have parameter NumWords, default 1024, meaning the number of tag SRAM entries (sets x ways).
REQ-002 The block SHALL have parameter DataWidth, default 128, meaning the tag word width in bits.
REQ-003 The block SHALL have parameter ByteWidth, default 8, meaning the byte-enable granularity.
REQ-004 The block SHALL have parameter Latency, default 1 (>=1), meaning the SRAM read latency in cycles.
REQ-005 The block SHALL derive AddrWidth = max(1, clog2(NumWords)) and BeWidth = ceil(DataWidth/ByteWidth).
REQ-006 The block SHALL have port clk_i, input, 1 bit: the single clock, rising edge.
REQ-007 The block SHALL have port rst_ni, input, 1 bit: the asynchronous, active-low reset.
REQ-008 The block SHALL have port init_req_i, input, 1 bit: a single-cycle request to re-clear the whole tag array.
REQ-009 The block SHALL have port init_busy_o, output, 1 bit: a clear sweep is pending or in progress.
REQ-010 The block SHALL have port init_done_o, output, 1 bit: a one-cycle pulse when a sweep completes.
REQ-011 The lookup ports SHALL be:
- lu_valid_i, input, 1 bit.
- lu_ready_o, output, 1 bit.
- lu_we_i, input, 1 bit.
- lu_addr_i, input, AddrWidth bits.
- lu_wdata_i, input, DataWidth bits.
- lu_be_i, input, BeWidth bits.
REQ-012 The response ports SHALL be:
- rsp_valid_o, output, 1 bit.
- rsp_rdata_o, output, DataWidth bits.
- There is no backpressure on the response.
REQ-013 The SRAM-side ports SHALL be:
- sram_req_o, output, 1 bit.
- sram_we_o, output, 1 bit.
- sram_addr_o, output, AddrWidth bits.
- sram_wdata_o, output, DataWidth bits.
- sram_be_o, output, BeWidth bits.
- sram_rdata_i, input, DataWidth bits.

Function
REQ-014 The FSM SHALL have exactly three states: START, INIT and SERVE.
REQ-015 The FSM reset state SHALL be START, and START SHALL go to INIT unconditionally on the next clock edge.
REQ-016 In INIT, each cycle the block SHALL drive:
- sram_req_o=1, sram_we_o=1.
- sram_addr_o=cnt, sram_wdata_o='0, sram_be_o='1.
- cnt is an AddrWidth-bit sweep counter.
REQ-017 The sweep counter SHALL step as follows:
- In INIT with cnt < NumWords-1: cnt increments.
- In INIT with cnt == NumWords-1: the FSM goes to SERVE and cnt clears to 0.
- A sweep therefore takes exactly NumWords cycles.
REQ-018 init_done_o SHALL be 1 only in the first SERVE cycle after an INIT.
REQ-019 init_busy_o SHALL be 1 in START and INIT, and 0 in SERVE.
REQ-020 lu_ready_o SHALL be 0 in START and INIT.
REQ-021 In SERVE, lu_ready_o SHALL equal !init_req_i.
REQ-022 A lookup SHALL be accepted when lu_valid_i && lu_ready_o. In that cycle:
- sram_req_o=1.
- sram_we_o, sram_addr_o, sram_wdata_o and sram_be_o equal the lu_* inputs combinationally.
REQ-023 In SERVE with no accepted lookup, sram_req_o SHALL be 0; the other SRAM outputs are don't-care.
REQ-024 In SERVE, init_req_i=1 SHALL:
- take priority over a same-cycle lookup, which is not accepted;
- move the FSM to INIT with cnt=0.
REQ-025 init_req_i SHALL be ignored in START and INIT; no sweep is queued or restarted.
REQ-026 Responses SHALL be generated as follows:
- An accepted read (lu_we_i=0) sets rsp_valid_o=1 exactly Latency cycles later, for one cycle.
- rsp_rdata_o = sram_rdata_i in that cycle.
- Tracking uses a Latency-deep valid shift register.
- Accepted writes produce no response.
REQ-027 Back-to-back accepted reads SHALL produce back-to-back responses with no bubbles.
REQ-028 Reads in flight when a sweep starts SHALL still return their responses at the scheduled cycle.
REQ-029 rsp_rdata_o SHALL be don't-care whenever rsp_valid_o=0.
REQ-030 lu_addr_i >= NumWords SHALL be forwarded unchanged and SHALL be flagged by a simulation assertion; it is a caller error.
REQ-031 Once asserted while lu_ready_o=0, lu_valid_i and its payload SHALL be held stable by the requester; a simulation assertion SHALL check this.

Reset
REQ-032 While rst_ni=0, the block SHALL drive:
- state=START, cnt=0, response shift register cleared.
- sram_req_o=0, lu_ready_o=0, init_busy_o=1, init_done_o=0, rsp_valid_o=0.
REQ-033 Reset asserted mid-sweep or with reads in flight SHALL abandon all pending work; no response is emitted after reset.
REQ-034 After reset release, a full sweep SHALL always run before the first lookup is accepted.

Verification
Parameters for all scenarios: NumWords=8, DataWidth=16, ByteWidth=8, Latency=1 unless stated.
REQ-035 Reset release -> 1 START cycle, then 8 INIT cycles writing addr 0..7 with wdata 0x0000 and be 2'b11 -> init_done_o pulses in the first SERVE cycle, with init_busy_o=0 and lu_ready_o=1.
REQ-036 Write addr 3 data 0xABCD be 2'b11, then read addr 3 -> rsp_valid_o=1 exactly 1 cycle after the read accept, with rsp_rdata_o=0xABCD; the write gives no response.
REQ-037 init_req_i=1 with lu_valid_i=1 (read addr 3) in the same SERVE cycle -> lookup not accepted; 8-cycle sweep runs; the held read is accepted in the first SERVE cycle and returns 0x0000.
REQ-038 Reads to addr 1, 2, 3 on consecutive cycles -> rsp_valid_o high for 3 consecutive cycles, data in order 1, 2, 3.
REQ-039 rst_ni pulsed low while cnt=4 in INIT -> all outputs take their reset values; after release the sweep restarts at addr 0 and lasts 8 cycles.
REQ-040 Latency=2, read addr 5 -> rsp_valid_o=1 exactly 2 cycles after accept; init_req_i during INIT -> ignored, sweep length unchanged.

Source files
------------

// File: rtl/axi_llc_tag_sram_ctrl.sv
// -----------------------------------------------------------------------------
// axi_llc_tag_sram_ctrl
//
// Front end for the LLC tag SRAM. After every reset, and on request, it sweeps
// the whole tag array and clears it to zero. Once the sweep is finished it
// forwards single-cycle lookups (reads or byte-masked writes) to the SRAM and
// returns read data Latency cycles later.
//
// Ports
//   clk_i, rst_ni      clock (rising edge), asynchronous active-low reset
//   init_req_i         one-cycle request to clear the tag array again
//   init_busy_o        a clear sweep is pending or in progress
//   init_done_o        one-cycle pulse in the first serve cycle after a sweep
//   lu_valid_i/ready_o lookup handshake
//   lu_we_i, lu_addr_i, lu_wdata_i, lu_be_i  lookup payload
//   rsp_valid_o        read response strobe (no backpressure)
//   rsp_rdata_o        read response data
//   sram_*             SRAM macro request side, sram_rdata_i read data
// -----------------------------------------------------------------------------
module axi_llc_tag_sram_ctrl #(
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned DataWidth = 128,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned Latency   = 1,
  localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
  localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 init_req_i,
  output logic                 init_busy_o,
  output logic                 init_done_o,
  input  logic                 lu_valid_i,
  output logic                 lu_ready_o,
  input  logic                 lu_we_i,
  input  logic [AddrWidth-1:0] lu_addr_i,
  input  logic [DataWidth-1:0] lu_wdata_i,
  input  logic [BeWidth-1:0]   lu_be_i,
  output logic                 rsp_valid_o,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [BeWidth-1:0]   sram_be_o,
  input  logic [DataWidth-1:0] sram_rdata_i
);

  typedef enum logic [1:0] {
    START = 2'd0,
    INIT  = 2'd1,
    SERVE = 2'd2
  } state_e;

  localparam logic [AddrWidth-1:0] CntLast = AddrWidth'(NumWords - 1);
  localparam logic [AddrWidth-1:0] CntOne  = AddrWidth'(1);

  state_e               r_state;
  state_e               w_next_state;
  logic [AddrWidth-1:0] r_cnt;
  logic [AddrWidth-1:0] w_next_cnt;
  logic                 r_done;
  logic [Latency-1:0]   r_rsp_sr;
  logic                 w_accept;
  logic                 w_rd_accept;
  logic                 w_sweep_last;

  assign w_sweep_last = (r_cnt == CntLast);
  assign w_accept     = lu_valid_i && lu_ready_o;
  assign w_rd_accept  = w_accept && !lu_we_i;

  // State, sweep counter and done pulse registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= START;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      // The last sweep write makes the following cycle the first serve cycle
      r_done  <= (r_state == INIT) && w_sweep_last;
    end
  end

  // Next-state logic and SRAM / handshake outputs
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    init_busy_o  = 1'b1;
    lu_ready_o   = 1'b0;
    sram_req_o   = 1'b0;
    sram_we_o    = lu_we_i;
    sram_addr_o  = lu_addr_i;
    sram_wdata_o = lu_wdata_i;
    sram_be_o    = lu_be_i;
    case (r_state)
      START: begin
        w_next_state = INIT;
        w_next_cnt   = '0;
      end
      INIT: begin
        sram_req_o   = 1'b1;
        sram_we_o    = 1'b1;
        sram_addr_o  = r_cnt;
        sram_wdata_o = '0;
        sram_be_o    = '1;
        if (w_sweep_last) begin
          w_next_state = SERVE;
          w_next_cnt   = '0;
        end else begin
          w_next_cnt   = r_cnt + CntOne;
        end
      end
      SERVE: begin
        init_busy_o = 1'b0;
        // A re-init request wins over a lookup presented in the same cycle
        lu_ready_o  = !init_req_i;
        if (init_req_i) begin
          w_next_state = INIT;
          w_next_cnt   = '0;
        end else if (lu_valid_i) begin
          sram_req_o   = 1'b1;
        end else begin
          sram_req_o   = 1'b0;
        end
      end
      default: begin
        w_next_state = START;
        w_next_cnt   = '0;
      end
    endcase
  end

  // Read-response valid pipeline, one stage per cycle of SRAM latency
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rsp_sr <= '0;
    end else begin
      for (int i = Latency - 1; i > 0; i--) begin
        r_rsp_sr[i] <= r_rsp_sr[i-1];
      end
      r_rsp_sr[0] <= w_rd_accept;
    end
  end

  assign init_done_o = r_done;
  assign rsp_valid_o = r_rsp_sr[Latency-1];
  assign rsp_rdata_o = sram_rdata_i;

  axi_llc_tag_sram_ctrl_chk #(
    .NumWords  (NumWords),
    .AddrWidth (AddrWidth),
    .DataWidth (DataWidth),
    .BeWidth   (BeWidth)
  ) u_chk (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .lu_valid_i (lu_valid_i),
    .lu_ready_i (lu_ready_o),
    .lu_we_i    (lu_we_i),
    .lu_addr_i  (lu_addr_i),
    .lu_wdata_i (lu_wdata_i),
    .lu_be_i    (lu_be_i)
  );

endmodule

// -----------------------------------------------------------------------------
// axi_llc_tag_sram_ctrl_chk
//
// Simulation checks on the lookup requester: a stalled lookup must be held
// stable until accepted, and addresses must lie inside the tag array.
// Ports mirror the lookup interface of axi_llc_tag_sram_ctrl (ready as input).
// -----------------------------------------------------------------------------
module axi_llc_tag_sram_ctrl_chk #(
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned AddrWidth = 10,
  parameter int unsigned DataWidth = 128,
  parameter int unsigned BeWidth   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 lu_valid_i,
  input  logic                 lu_ready_i,
  input  logic                 lu_we_i,
  input  logic [AddrWidth-1:0] lu_addr_i,
  input  logic [DataWidth-1:0] lu_wdata_i,
  input  logic [BeWidth-1:0]   lu_be_i
);

  logic                 r_pend;
  logic                 r_we;
  logic [AddrWidth-1:0] r_addr;
  logic [DataWidth-1:0] r_wdata;
  logic [BeWidth-1:0]   r_be;

  // Remember a lookup that was presented but not accepted
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pend  <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else begin
      r_pend  <= lu_valid_i && !lu_ready_i;
      r_we    <= lu_we_i;
      r_addr  <= lu_addr_i;
      r_wdata <= lu_wdata_i;
      r_be    <= lu_be_i;
    end
  end

  // Requester protocol checks
  always @(posedge clk_i) begin
    if (rst_ni && r_pend) begin
      assert (lu_valid_i && (lu_we_i == r_we) && (lu_addr_i == r_addr) &&
              (lu_wdata_i == r_wdata) && (lu_be_i == r_be));
    end
    if (rst_ni && lu_valid_i) begin
      assert (32'(lu_addr_i) < NumWords);
    end
  end

endmodule

// File: tb/tb_axi_llc_tag_sram_ctrl.sv
module tb_axi_llc_tag_sram_ctrl;

  localparam int NW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        init_req, lu_valid, lu_we;
  logic [2:0]  lu_addr;
  logic [15:0] lu_wdata;
  logic [1:0]  lu_be;

  logic        busy1, done1, ready1, rv1, sreq1, swe1;
  logic [15:0] rd1, swd1, srd1;
  logic [2:0]  saddr1;
  logic [1:0]  sbe1;
  logic        busy2, done2, ready2, rv2, sreq2, swe2;
  logic [15:0] rd2, swd2, srd2;
  logic [2:0]  saddr2;
  logic [1:0]  sbe2;

  axi_llc_tag_sram_ctrl #(.NumWords(8), .DataWidth(16), .ByteWidth(8), .Latency(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .init_req_i(init_req), .init_busy_o(busy1), .init_done_o(done1),
    .lu_valid_i(lu_valid), .lu_ready_o(ready1), .lu_we_i(lu_we), .lu_addr_i(lu_addr),
    .lu_wdata_i(lu_wdata), .lu_be_i(lu_be), .rsp_valid_o(rv1), .rsp_rdata_o(rd1),
    .sram_req_o(sreq1), .sram_we_o(swe1), .sram_addr_o(saddr1), .sram_wdata_o(swd1),
    .sram_be_o(sbe1), .sram_rdata_i(srd1));

  axi_llc_tag_sram_ctrl #(.NumWords(8), .DataWidth(16), .ByteWidth(8), .Latency(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .init_req_i(init_req), .init_busy_o(busy2), .init_done_o(done2),
    .lu_valid_i(lu_valid), .lu_ready_o(ready2), .lu_we_i(lu_we), .lu_addr_i(lu_addr),
    .lu_wdata_i(lu_wdata), .lu_be_i(lu_be), .rsp_valid_o(rv2), .rsp_rdata_o(rd2),
    .sram_req_o(sreq2), .sram_we_o(swe2), .sram_addr_o(saddr2), .sram_wdata_o(swd2),
    .sram_be_o(sbe2), .sram_rdata_i(srd2));

  // Behavioural SRAM macros: byte-masked write, read data after 1 or 2 cycles
  logic [15:0] sm1 [8];
  logic [15:0] sm2 [8];
  logic [15:0] p1, p2a, p2b;
  always @(posedge clk) begin
    if (sreq1 && swe1) begin
      for (int b = 0; b < 2; b++) if (sbe1[b]) sm1[saddr1][8*b +: 8] <= swd1[8*b +: 8];
    end
    p1 <= (sreq1 && !swe1) ? sm1[saddr1] : 16'hDEAD;
  end
  always @(posedge clk) begin
    if (sreq2 && swe2) begin
      for (int b = 0; b < 2; b++) if (sbe2[b]) sm2[saddr2][8*b +: 8] <= swd2[8*b +: 8];
    end
    p2a <= (sreq2 && !swe2) ? sm2[saddr2] : 16'hDEAD;
    p2b <= p2a;
  end
  assign srd1 = p1;
  assign srd2 = p2b;

  // Reference model: phase of the controller, sweep position, tag contents,
  // and per-latency lists of promised responses (cycle due, data).
  typedef struct { int due; logic [15:0] data; } rsp_t;
  rsp_t        q1[$];
  rsp_t        q2[$];
  int          mode;   // 0 = START, 1 = INIT, 2 = SERVE
  int          cnt_m;
  bit          fresh;  // first SERVE cycle after a sweep
  logic [15:0] mem_ref [8];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_dut(string d, bit acc, bit ready_e, bit ev, logic [15:0] ed,
                         logic busy, logic done, logic ready, logic rv, logic [15:0] rd,
                         logic sreq, logic swe, logic [2:0] saddr, logic [15:0] swd, logic [1:0] sbe);
    chk({d, ".busy"},  32'(busy),  32'(mode != 2));
    chk({d, ".done"},  32'(done),  32'(mode == 2 && fresh));
    chk({d, ".ready"}, 32'(ready), 32'(ready_e));
    chk({d, ".sram_req"}, 32'(sreq), 32'((mode == 1) || acc));
    if (mode == 1) begin
      chk({d, ".init_we"},    32'(swe),   32'(1));
      chk({d, ".init_addr"},  32'(saddr), 32'(cnt_m));
      chk({d, ".init_wdata"}, 32'(swd),   32'(0));
      chk({d, ".init_be"},    32'(sbe),   32'(3));
    end else if (acc) begin
      chk({d, ".lu_we"},    32'(swe),   32'(lu_we));
      chk({d, ".lu_addr"},  32'(saddr), 32'(lu_addr));
      chk({d, ".lu_wdata"}, 32'(swd),   32'(lu_wdata));
      chk({d, ".lu_be"},    32'(sbe),   32'(lu_be));
    end
    chk({d, ".rsp_valid"}, 32'(rv), 32'(ev));
    if (ev) chk({d, ".rsp_rdata"}, 32'(rd), 32'(ed));
  endtask

  // One clock cycle: check outputs for the current inputs, then advance model
  task automatic step();
    bit          ready_e, acc, ev1, ev2;
    logic [15:0] ed1, ed2;
    #1;
    ready_e = (mode == 2) && !init_req && rst_n;
    acc     = lu_valid && ready_e;
    ev1 = (q1.size() > 0) && (q1[0].due == cyc);
    ed1 = ev1 ? q1[0].data : 16'h0;
    ev2 = (q2.size() > 0) && (q2[0].due == cyc);
    ed2 = ev2 ? q2[0].data : 16'h0;
    chk_dut("L1", acc, ready_e, ev1, ed1, busy1, done1, ready1, rv1, rd1, sreq1, swe1, saddr1, swd1, sbe1);
    chk_dut("L2", acc, ready_e, ev2, ed2, busy2, done2, ready2, rv2, rd2, sreq2, swe2, saddr2, swd2, sbe2);
    @(posedge clk);
    if (ev1) void'(q1.pop_front());
    if (ev2) void'(q2.pop_front());
    if (rst_n) begin
      case (mode)
        0: begin mode = 1; cnt_m = 0; fresh = 0; end
        1: begin
          mem_ref[cnt_m] = 16'h0000;
          if (cnt_m == NW - 1) begin mode = 2; cnt_m = 0; fresh = 1; end
          else cnt_m++;
        end
        default: begin
          fresh = 0;
          if (init_req) begin
            mode = 1; cnt_m = 0;
          end else if (acc) begin
            if (lu_we) begin
              for (int b = 0; b < 2; b++) if (lu_be[b]) mem_ref[lu_addr][8*b +: 8] = lu_wdata[8*b +: 8];
            end else begin
              q1.push_back('{cyc + 1, mem_ref[lu_addr]});
              q2.push_back('{cyc + 2, mem_ref[lu_addr]});
            end
          end
        end
      endcase
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic apply_reset(int n);
    rst_n = 1'b0;
    mode = 0; cnt_m = 0; fresh = 0;
    q1.delete(); q2.delete();
    repeat (n) step();
    rst_n = 1'b1;
  endtask

  task automatic drive(bit v, bit we, int a, logic [15:0] d, logic [1:0] be);
    lu_valid = v; lu_we = we; lu_addr = 3'(a); lu_wdata = d; lu_be = be;
  endtask

  initial begin
    bit pend;
    rst_n = 1'b0; init_req = 1'b0;
    drive(0, 0, 0, 16'h0, 2'b00);
    @(negedge clk);

    // Power-on reset, full sweep, first serve cycle
    apply_reset(2);
    repeat (12) step();

    // Write then read address 3
    drive(1, 1, 3, 16'hABCD, 2'b11); step();
    drive(1, 0, 3, 16'h0, 2'b00);    step();
    drive(0, 0, 0, 16'h0, 2'b00);    repeat (2) step();

    // Re-init beats a same-cycle read; read held through the sweep,
    // with a stray init request inside the sweep that must be ignored
    init_req = 1'b1; drive(1, 0, 3, 16'h0, 2'b00); step();
    init_req = 1'b0; repeat (4) step();
    init_req = 1'b1; step();
    init_req = 1'b0;
    for (int i = 0; i < 20 && mode != 2; i++) step();
    step();
    drive(0, 0, 0, 16'h0, 2'b00); repeat (3) step();

    // Back-to-back reads of 1, 2, 3
    for (int a = 1; a <= 3; a++) begin drive(1, 1, a, 16'(a * 16'h1111), 2'b11); step(); end
    for (int a = 1; a <= 3; a++) begin drive(1, 0, a, 16'h0, 2'b00); step(); end
    drive(0, 0, 0, 16'h0, 2'b00); repeat (3) step();

    // Read in flight as a sweep starts, then reset while cnt = 4
    drive(1, 0, 2, 16'h0, 2'b00); step();
    drive(0, 0, 0, 16'h0, 2'b00); init_req = 1'b1; step();
    init_req = 1'b0;
    for (int i = 0; i < 20 && !(mode == 1 && cnt_m == 4); i++) step();
    apply_reset(2);
    repeat (11) step();

    // Reset with a read in flight: no response afterwards
    drive(1, 0, 1, 16'h0, 2'b00); step();
    drive(0, 0, 0, 16'h0, 2'b00);
    apply_reset(1);
    repeat (12) step();

    // Randomized traffic, stalled requests held stable
    pend = 0;
    for (int i = 0; i < 400; i++) begin
      if (!pend) drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
                       16'($urandom), 2'($urandom_range(0, 3)));
      init_req = ($urandom_range(0, 29) == 0);
      pend = lu_valid && !((mode == 2) && !init_req);
      step();
    end
    init_req = 1'b0; drive(0, 0, 0, 16'h0, 2'b00);
    for (int i = 0; i < 12; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
